activation_unit: RTL and testbench



---
 rtl/activation_pkg.sv | 13 +
 rtl/activation_lane.sv | 35 +++
 rtl/activation_unit.sv | 100 ++++++++++
 tb/tb_activation_unit.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/activation_pkg.sv
// Shared mode encoding for the activation unit.
package activation_pkg;

    localparam int MODE_W = 2;

    typedef enum logic [MODE_W-1:0] {
        ACT_STEP  = 2'd0,
        ACT_RELU  = 2'd1,
        ACT_CLAMP = 2'd2,
        ACT_LEAKY = 2'd3
    } act_mode_e;

endpackage

// File: rtl/activation_lane.sv
// Single-channel activation function, purely combinational.
// ACTIVATION_UNIT_LEAKY_EN selects the shifter for mode 3; otherwise mode 3 falls back to RELU.
module activation_lane
    import activation_pkg::*;
#(
    parameter int Q_N        = 16,
    parameter int W          = 33
`ifdef ACTIVATION_UNIT_LEAKY_EN
    ,
    parameter int LEAK_SHIFT = 3
`endif
) (
    input  act_mode_e          mode,
    input  logic signed [W-1:0] x,
    output logic signed [W-1:0] y
);

    localparam logic signed [W-1:0] ONE = {{(W-Q_N-1){1'b0}}, 1'b1, {Q_N{1'b0}}};

    logic neg;
    assign neg = x[W-1];

    always_comb begin
        y = neg ? '0 : x;
        case (mode)
            ACT_STEP:  y = neg ? '0 : ONE;
            ACT_CLAMP: if (!neg && (x > ONE)) y = ONE;
`ifdef ACTIVATION_UNIT_LEAKY_EN
            ACT_LEAKY: if (neg) y = x >>> LEAK_SHIFT;
`endif
            default: ;
        endcase
    end

endmodule

// File: rtl/activation_unit.sv
// Two-stage N_CH-wide activation pipeline with valid/ready flow control and an active-channel counter.
// ACTIVATION_UNIT_LEAKY_EN enables the leaky slope in mode 3.
module activation_unit
    import activation_pkg::*;
#(
    parameter int SIGN       = 1,
    parameter int Q_M        = 16,
    parameter int Q_N        = 16,
    parameter int N_CH       = 4,
    parameter int LEAK_SHIFT = 3
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         valid_i,
    output logic                         ready_o,
    input  logic [MODE_W-1:0]            mode_i,
    input  logic [N_CH*(SIGN+Q_M+Q_N)-1:0] summation_i,
    output logic                         valid_o,
    input  logic                         ready_i,
    output logic [N_CH*(SIGN+Q_M+Q_N)-1:0] activation_o,
    output logic [15:0]                  active_cnt_o,
    input  logic                         clr_cnt_i
);

    localparam int W      = SIGN + Q_M + Q_N;
    localparam int STAGES = 2;
    localparam int NZ_W   = $clog2(N_CH + 1);

    if (SIGN != 1 || LEAK_SHIFT < 1 || LEAK_SHIFT > Q_M + Q_N) begin : g_bad_param
        $error("activation_unit: illegal SIGN or LEAK_SHIFT");
    end

    logic [STAGES:1]          vld_pipe;
    logic                     adv;
    act_mode_e                s1_mode;
    logic [N_CH-1:0][W-1:0]   s1_x;
    logic [N_CH-1:0][W-1:0]   lane_y;
    logic [N_CH-1:0][W-1:0]   s2_y;

    // The whole pipe moves as one; a stalled output freezes stage 1 too.
    assign adv          = ~valid_o | ready_i;
    assign ready_o      = adv;
    assign valid_o      = vld_pipe[STAGES];
    assign activation_o = s2_y;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            vld_pipe <= '0;
            s2_y     <= '0;
        end else if (adv) begin
            vld_pipe <= {vld_pipe[STAGES-1:1], valid_i};
            if (vld_pipe[1]) s2_y <= lane_y;
        end
    end

    always_ff @(posedge clk_i) begin
        if (adv && valid_i) begin
            s1_mode <= act_mode_e'(mode_i);
            s1_x    <= summation_i;
        end
    end

    for (genvar k = 0; k < N_CH; k++) begin : g_lane
        activation_lane #(
            .Q_N       (Q_N),
            .W         (W)
`ifdef ACTIVATION_UNIT_LEAKY_EN
            ,
            .LEAK_SHIFT(LEAK_SHIFT)
`endif
        ) u_lane (
            .mode (s1_mode),
            .x    (s1_x[k]),
            .y    (lane_y[k])
        );
    end

    logic [NZ_W-1:0] nz;
    logic            xfer;
    logic [15:0]     cnt_base;
    logic [16:0]     cnt_sum;

    always_comb begin
        nz = '0;
        for (int k = 0; k < N_CH; k++)
            if (|s2_y[k]) nz = nz + NZ_W'(1);
    end

    // A clear coinciding with a transfer restarts from that beat's count.
    assign xfer     = valid_o & ready_i;
    assign cnt_base = clr_cnt_i ? 16'h0 : active_cnt_o;
    assign cnt_sum  = {1'b0, cnt_base} + 17'(nz);

    always_ff @(posedge clk_i) begin
        if (rst_i)          active_cnt_o <= '0;
        else if (xfer)      active_cnt_o <= cnt_sum[16] ? 16'hFFFF : cnt_sum[15:0];
        else if (clr_cnt_i) active_cnt_o <= '0;
    end

endmodule

// File: tb/tb_activation_unit.sv
// Randomized + directed bench for activation_unit with a queue-based behavioural model.
module tb_activation_unit;

    localparam int Q_M = 16, Q_N = 16, N_CH = 4, LEAK = 3;
    localparam int W  = 1 + Q_M + Q_N;
    localparam int BW = N_CH * W;

    logic          clk_i = 1'b0;
    logic          rst_i, valid_i, ready_o, valid_o, ready_i, clr_cnt_i;
    logic [1:0]    mode_i;
    logic [BW-1:0] summation_i, activation_o;
    logic [15:0]   active_cnt_o;

    activation_unit #(.SIGN(1), .Q_M(Q_M), .Q_N(Q_N), .N_CH(N_CH), .LEAK_SHIFT(LEAK)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .valid_i(valid_i), .ready_o(ready_o),
        .mode_i(mode_i), .summation_i(summation_i), .valid_o(valid_o), .ready_i(ready_i),
        .activation_o(activation_o), .active_cnt_o(active_cnt_o), .clr_cnt_i(clr_cnt_i)
    );

    always #5 clk_i = ~clk_i;

    int n_tests = 0, n_fail = 0, n_out = 0;

    task automatic chk(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic longint floor_div(input longint x, input longint d);
        longint q;
        q = x / d;
        if ((x % d) != 0 && x < 0) q = q - 1;
        return q;
    endfunction

    function automatic logic [W-1:0] ref_act(input int m, input logic [W-1:0] xv);
        longint x, one, r;
        x   = longint'($signed(xv));
        one = longint'(1) << Q_N;
        case (m)
            0: r = (x >= 0) ? one : 0;
            1: r = (x >= 0) ? x : 0;
            2: r = (x < 0) ? 0 : ((x > one) ? one : x);
`ifdef ACTIVATION_UNIT_LEAKY_EN
            default: r = (x >= 0) ? x : floor_div(x, longint'(1) << LEAK);
`else
            default: r = (x >= 0) ? x : 0;
`endif
        endcase
        return r[W-1:0];
    endfunction

    function automatic logic [BW-1:0] ref_beat(input int m, input logic [BW-1:0] d);
        logic [BW-1:0] r;
        for (int k = 0; k < N_CH; k++) r[k*W +: W] = ref_act(m, d[k*W +: W]);
        return r;
    endfunction

    function automatic logic [BW-1:0] pack4(input logic [W-1:0] c0, input logic [W-1:0] c1,
                                            input logic [W-1:0] c2, input logic [W-1:0] c3);
        return {c3, c2, c1, c0};
    endfunction

    function automatic logic [W-1:0] rnd_x();
        logic [W-1:0] v;
        case ($urandom_range(5))
            0: v = '0;
            1: v = 33'h0_0001_0000;
            2: v = 33'h0_0001_0001;
            3: v = 33'h1_FFFF_FFFF;
            4: v = 33'h1_FFF8_0000;
            default: v = {1'($urandom_range(1)), 32'($urandom)};
        endcase
        return v;
    endfunction

    // Model: expected beats in accept order, expected counter value.
    logic [BW-1:0] q[$];
    logic [BW-1:0] hold_val, exp_b;
    logic          hold_prev = 1'b0;
    int            mcnt = 0;

    always @(negedge clk_i) begin
        if (rst_i) begin
            q.delete();
            mcnt      = 0;
            hold_prev = 1'b0;
        end else begin
            chk("active_cnt", BW'(active_cnt_o), BW'(mcnt));
            chk("ready_o", BW'(ready_o), BW'(!valid_o || ready_i));
            if (hold_prev) begin
                chk("stall_valid", BW'(valid_o), BW'(1));
                chk("stall_data", activation_o, hold_val);
            end
            if (valid_o && ready_i) begin
                if (q.size() == 0) begin
                    chk("spurious_out", BW'(valid_o), BW'(0));
                end else begin
                    int nz;
                    exp_b = q.pop_front();
                    chk("out_data", activation_o, exp_b);
                    n_out++;
                    nz = 0;
                    for (int k = 0; k < N_CH; k++) if (exp_b[k*W +: W] != '0) nz++;
                    mcnt = (clr_cnt_i ? 0 : mcnt) + nz;
                    if (mcnt > 16'hFFFF) mcnt = 16'hFFFF;
                end
            end else if (clr_cnt_i) begin
                mcnt = 0;
            end
            hold_prev = valid_o && !ready_i;
            hold_val  = activation_o;
            if (valid_i && ready_o) q.push_back(ref_beat(int'(mode_i), summation_i));
        end
    end

    task automatic send(input logic [1:0] m, input logic [BW-1:0] d);
        int n = 0;
        valid_i = 1'b1; mode_i = m; summation_i = d;
        @(negedge clk_i);
        while (!ready_o && n < 100) begin @(negedge clk_i); n++; end
        if (n >= 100) chk("send_timeout", BW'(ready_o), BW'(1));
        @(posedge clk_i); #1;
        valid_i = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk_i); #1; end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        rst_i = 1'b1; valid_i = 1'b0; ready_i = 1'b1; clr_cnt_i = 1'b0;
        mode_i = 2'd0; summation_i = '0;
        repeat (2) @(posedge clk_i);
        #1 rst_i = 1'b0;
        chk("rst_valid_o", BW'(valid_o), BW'(0));
        chk("rst_act", activation_o, BW'(0));
        chk("rst_cnt", BW'(active_cnt_o), BW'(0));
        chk("rst_ready", BW'(ready_o), BW'(1));

        // STEP, exact 2-cycle latency, counter from cleared state
        clr_cnt_i = 1'b1; idle(1); clr_cnt_i = 1'b0;
        send(2'd0, pack4(33'h0, 33'h1_FFFF_FFFF, 33'h1, 33'h1_0000_0000));
        idle(1);
        chk("step_valid", BW'(valid_o), BW'(1));
        chk("step_data", activation_o, pack4(33'h10000, 33'h0, 33'h10000, 33'h0));
        idle(1);
        chk("step_cnt", BW'(active_cnt_o), BW'(2));

        send(2'd2, pack4(33'h18000, 33'h08000, 33'h1_FFFF_FFFF, 33'h10000));
        idle(1);
        chk("clamp_data", activation_o, pack4(33'h10000, 33'h08000, 33'h0, 33'h10000));

        send(2'd3, pack4(33'h1_FFF8_0000, 33'h1_FFFF_FFFF, 33'h10000, 33'h0));
        idle(1);
`ifdef ACTIVATION_UNIT_LEAKY_EN
        chk("leaky_data", activation_o, pack4(33'h1_FFFF_0000, 33'h1_FFFF_FFFF, 33'h10000, 33'h0));
`else
        chk("leaky_data", activation_o, pack4(33'h0, 33'h0, 33'h10000, 33'h0));
`endif
        idle(3);

        // 5-beat stream with a 3-cycle stall on the first output
        base = n_out;
        fork
            begin
                for (int i = 0; i < 5; i++)
                    send(2'($urandom_range(3)), pack4(rnd_x(), rnd_x(), rnd_x(), rnd_x()));
            end
            begin
                int n = 0;
                @(posedge clk_i); #1;
                while (!valid_o && n < 20) begin @(posedge clk_i); #1; n++; end
                ready_i = 1'b0;
                repeat (3) @(posedge clk_i);
                #1 ready_i = 1'b1;
            end
        join
        idle(6);
        chk("stream_count", BW'(n_out - base), BW'(5));
        chk("stream_drained", BW'(q.size()), BW'(0));

        // randomized traffic with back-pressure and counter clears
        for (int i = 0; i < 400; i++) begin
            valid_i     = ($urandom_range(3) != 0);
            mode_i      = 2'($urandom_range(3));
            summation_i = pack4(rnd_x(), rnd_x(), rnd_x(), rnd_x());
            ready_i     = ($urandom_range(3) != 0);
            clr_cnt_i   = ($urandom_range(15) == 0);
            idle(1);
        end
        valid_i = 1'b0; ready_i = 1'b1; clr_cnt_i = 1'b0;
        idle(4);
        chk("rand_drained", BW'(q.size()), BW'(0));

        // reset while stalled with two beats in flight
        ready_i = 1'b0;
        send(2'd1, pack4(33'h5, 33'h6, 33'h7, 33'h8));
        send(2'd1, pack4(33'h9, 33'hA, 33'hB, 33'hC));
        chk("pre_rst_valid", BW'(valid_o), BW'(1));
        rst_i = 1'b1; idle(1); rst_i = 1'b0;
        chk("mid_rst_valid", BW'(valid_o), BW'(0));
        chk("mid_rst_cnt", BW'(active_cnt_o), BW'(0));
        ready_i = 1'b1;
        send(2'd1, pack4(33'h1, 33'h2, 33'h3, 33'h1_0000_0004));
        idle(1);
        chk("post_rst_valid", BW'(valid_o), BW'(1));
        chk("post_rst_data", activation_o, pack4(33'h1, 33'h2, 33'h3, 33'h0));
        idle(3);

        // counter preload to FFFE, then saturation, then clear with concurrent transfer
        clr_cnt_i = 1'b1; idle(1); clr_cnt_i = 1'b0;
        for (int i = 0; i < 16383; i++) send(2'd1, pack4(33'h1, 33'h1, 33'h1, 33'h1));
        send(2'd1, pack4(33'h1, 33'h1, 33'h0, 33'h0));
        idle(4);
        chk("cnt_preload", BW'(active_cnt_o), BW'(16'hFFFE));
        send(2'd1, pack4(33'h1, 33'h1, 33'h1, 33'h1));
        idle(4);
        chk("cnt_saturate", BW'(active_cnt_o), BW'(16'hFFFF));
        send(2'd0, pack4(33'h1, 33'h1, 33'h1, 33'h1_0000_0000));
        idle(1);
        clr_cnt_i = 1'b1;
        idle(1);
        clr_cnt_i = 1'b0;
        chk("cnt_clr_xfer", BW'(active_cnt_o), BW'(3));
        idle(3);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
